// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: FSM states, slice width and default operand width.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int SLICE_W   = 2;
   localparam int DEFAULT_N = 16;

endpackage

// File: rtl/serial_adder_add_slice.sv
// Combinational 2-bit ripple slice reused by serial_adder once per RUN cycle.
module add_slice
   import serial_adder_pkg::*;
(
   input  logic               cin,
   input  logic [SLICE_W-1:0] lhs,
   input  logic [SLICE_W-1:0] rhs,
   output logic [SLICE_W-1:0] out,
   output logic               cout
);

   logic [SLICE_W:0] total;

   assign total = {1'b0, lhs} + {1'b0, rhs} + {{SLICE_W{1'b0}}, cin};
   assign out   = total[SLICE_W-1:0];
   assign cout  = total[SLICE_W];

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: N-bit operands summed two bits per cycle through one add_slice,
// with a valid/ready handshake on both the operand and result sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         io_in_valid,
   output logic         io_in_ready,
   input  logic [N-1:0] io_in_lhs,
   input  logic [N-1:0] io_in_rhs,
   input  logic         io_in_cin,
   output logic         io_out_valid,
   input  logic         io_out_ready,
   output logic [N-1:0] io_out_sum,
   output logic         io_out_cout
);

   localparam int STEPS = N / SLICE_W;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   state_t             state;
   state_t             state_nxt;
   logic [N-1:0]       lhs_q;
   logic [N-1:0]       rhs_q;
   logic [N-1:0]       res_q;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;
   logic [N+1:0]       res_shift;
   logic               last_step;

   add_slice u_slice (
      .cin  (carry_q),
      .lhs  (lhs_q[SLICE_W-1:0]),
      .rhs  (rhs_q[SLICE_W-1:0]),
      .out  (slice_sum),
      .cout (slice_cout)
   );

   // New slice bits enter at the top so after STEPS shifts the LSB slice lands at [1:0].
   assign res_shift = {slice_sum, res_q};
   assign last_step = (cnt_q == CNT_W'(STEPS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (io_in_valid)  state_nxt = RUN;
         RUN:     if (last_step)    state_nxt = DONE;
         DONE:    if (io_out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lhs_q   <= '0;
         rhs_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (io_in_valid) begin
                  lhs_q   <= io_in_lhs;
                  rhs_q   <= io_in_rhs;
                  carry_q <= io_in_cin;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               res_q   <= res_shift[N+1:SLICE_W];
               carry_q <= slice_cout;
               lhs_q   <= lhs_q >> SLICE_W;
               rhs_q   <= rhs_q >> SLICE_W;
               cnt_q   <= cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign io_in_ready  = (state == IDLE);
   assign io_out_valid = (state == DONE);
   assign io_out_sum   = res_q;
   assign io_out_cout  = carry_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: N, 16, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: io_in_valid  input  1  operand set offered.
REQ-005 Port: io_in_ready  output  1  block can accept an operand set.
REQ-006 Port: io_in_lhs  input  N  left operand.
REQ-007 Port: io_in_rhs  input  N  right operand.
REQ-008 Port: io_in_cin  input  1  carry-in.
REQ-009 Port: io_out_valid  output  1  result available.
REQ-010 Port: io_out_ready  input  1  consumer accepts result.
REQ-011 Port: io_out_sum  output  N  sum bits [N-1:0].
REQ-012 Port: io_out_cout  output  1  carry-out of bit N-1.

Function
REQ-013 The block SHALL compute {io_out_cout, io_out_sum} = io_in_lhs + io_in_rhs + io_in_cin, modulo 2^(N+1), through a single 2-bit slice adder reused over N/2 cycles.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 io_in_ready SHALL be 1 in IDLE only; io_out_valid SHALL be 1 in DONE only; both are decoded from registered state.
REQ-016 IDLE, io_in_valid=1: capture lhs, rhs into shift registers, carry register <= io_in_cin, slice counter <= 0, go to RUN.
REQ-017 RUN, every cycle: slice adder takes lhs[1:0], rhs[1:0], carry register; result register shifts right 2 bits, inserting the 2 slice sum bits at [N-1:N-2]; carry register <= slice carry-out; operand registers shift right 2; counter increments.
REQ-018 RUN SHALL last exactly N/2 cycles; on the cycle counter = N/2-1 the next state is DONE.
REQ-019 Latency: handshake at edge k -> io_out_valid first high after edge k+N/2.
REQ-020 DONE: io_out_sum = result register, io_out_cout = carry register, both stable while io_out_valid=1 and io_out_ready=0.
REQ-021 DONE, io_out_ready=1: go to IDLE; next operand accepted no earlier than the following edge (max throughput one result per N/2+2 cycles).
REQ-022 io_in_valid in RUN or DONE SHALL be ignored and SHALL not alter state; io_out_ready outside DONE SHALL be ignored.
REQ-023 Counter width SHALL be clog2(N/2), min 1 bit; no wrap occurs because RUN exits at N/2-1.
REQ-024 N=2: RUN lasts one cycle; behaviour otherwise identical.

Reset
REQ-025 reset=1 SHALL asynchronously force state IDLE, counter 0, carry 0, result 0, operand registers 0.
REQ-026 During and after reset until the first operand: io_in_ready=1, io_out_valid=0, io_out_sum=0, io_out_cout=0.
REQ-027 Reset in RUN or DONE SHALL abort the operation; the in-flight result SHALL never be presented.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, RUN, DONE), the slice width constant (2), and the default N.
REQ-029 The 2-bit slice adder SHALL be one sub-module, add_slice (inputs cin, lhs[1:0], rhs[1:0]; outputs out[1:0], cout), purely combinational; all sequencing lives in serial_adder.

Verification (N=16)
REQ-030 lhs=0xFFFF, rhs=0x0001, cin=0 -> after 8 RUN cycles sum=0x0000, cout=1.
REQ-031 lhs=0x1234, rhs=0x4321, cin=1 -> sum=0x5556, cout=0; io_out_valid high exactly 8 cycles after handshake.
REQ-032 Hold io_out_ready=0 for 5 cycles in DONE -> io_out_valid, sum, cout stable all 5 cycles; io_in_ready=0 throughout.
REQ-033 Assert reset asynchronously at RUN cycle 3 -> outputs immediately at reset values, io_out_valid never asserts; subsequent 0x0001+0x0001 -> 0x0002, cout=0.
REQ-034 Pulse io_in_valid with new operands during RUN -> ignored; result equals first operand set.
REQ-035 Back-to-back random operands with io_out_ready=1, 1000 transactions -> every result matches lhs+rhs+cin reference model.
